pc_fetch_unit: RTL

Program-counter and instruction-fetch stage of the single-cycle LEGv8 datapath. Holds the PC, fetches each instruction through a request/acknowledge port to instruction memory, and presents it to decode. Computes the next PC from the sign-extended 64-bit immediate (`BusImm`) produced by the sign extender, together with the branch controls and the ALU `Zero` flag.

---
 rtl/pc_fetch_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage for the single-cycle LEGv8 core.
// Fetches through a req/ack port, holds the instruction until retire, then advances the PC.
module pc_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] BusImm,
    input  logic        Branch,
    input  logic        UncondBranch,
    input  logic        Zero,
    input  logic        Retire,
    output logic        ImemReq,
    output logic [63:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [63:0] PC,
    output logic [31:0] RetireCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;

    logic        take_branch;
    logic [63:0] branch_off;
    logic [63:0] next_pc;

    // UncondBranch wins over CBZ; the word offset loses BusImm[63:62] in the shift.
    assign take_branch = UncondBranch | (Branch & Zero);
    assign branch_off  = {BusImm[61:0], 2'b00};
    assign next_pc     = take_branch ? (pc_q + branch_off) : (pc_q + 64'd4);

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (ImemAck) begin
                    state_d = EXEC;
                    instr_d = ImemData;
                    valid_d = 1'b1;
                end
            end
            EXEC: begin
                if (Retire) begin
                    state_d = FETCH;
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign ImemReq     = (state_q == FETCH);
    assign ImemAddr    = pc_q;
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign InstrValid  = valid_q;
    assign RetireCount = count_q;

endmodule
